// File: rtl/fir_coeff_loader.sv
// Run-time coefficient loader: stages the unique half of a symmetric FIR set, mirrors it, swaps on clk_ena.
// Latency: swap on the first clk_ena edge after the last word (earliest next edge); swap_done/len_err registered.
// Backpressure: load_ready drops while a complete set waits for its swap and while reset is high.
module fir_coeff_loader #(
    parameter int COEFF_W    = 18,
    parameter int NUM_UNIQUE = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clk_ena,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [COEFF_W-1:0]                load_data,
    input  logic                              load_last,
    output logic [2*NUM_UNIQUE*COEFF_W-1:0]   coeffs,
    output logic                              busy,
    output logic                              swap_done,
    output logic                              len_err
);

    localparam int IDX_W = (NUM_UNIQUE > 1) ? $clog2(NUM_UNIQUE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_UNIQUE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COEFF_W-1:0] shadow_q [NUM_UNIQUE];
    logic [COEFF_W-1:0] shadow_d [NUM_UNIQUE];
    logic [COEFF_W-1:0] active_q [NUM_UNIQUE];
    logic [COEFF_W-1:0] active_d [NUM_UNIQUE];
    logic               swap_done_q, swap_done_d;
    logic               len_err_q, len_err_d;
    logic               xfer;

    assign load_ready = !reset && (state_q != S_COMMIT);
    assign xfer       = load_valid && load_ready;
    assign busy       = (state_q != S_IDLE);
    assign swap_done  = swap_done_q;
    assign len_err    = len_err_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        swap_done_d = 1'b0;
        len_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    shadow_d[0] = load_data;
                    if (NUM_UNIQUE == 1) begin
                        if (load_last) state_d = S_COMMIT;
                        else           len_err_d = 1'b1;
                    end else if (load_last) begin
                        len_err_d = 1'b1;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    shadow_d[idx_q] = load_data;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (load_last) begin
                            state_d = S_COMMIT;
                        end else begin
                            len_err_d = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end else if (load_last) begin
                        idx_d     = '0;
                        len_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_COMMIT: begin
                // Swap only on a sample boundary so no sample sees a mixed set.
                if (clk_ena) begin
                    active_d    = shadow_q;
                    swap_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            swap_done_q <= 1'b0;
            len_err_q   <= 1'b0;
            for (int i = 0; i < NUM_UNIQUE; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            swap_done_q <= swap_done_d;
            len_err_q   <= len_err_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    // Symmetric taps: the upper half mirrors the lower half.
    for (genvar k = 0; k < 2 * NUM_UNIQUE; k++) begin : g_tap
        if (k < NUM_UNIQUE) begin : g_lo
            assign coeffs[k*COEFF_W +: COEFF_W] = active_q[k];
        end else begin : g_hi
            assign coeffs[k*COEFF_W +: COEFF_W] = active_q[2*NUM_UNIQUE-1-k];
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: vector table, directed corner sequences, random traffic vs a set-level model.
// Inputs driven 1 time unit after the rising edge, outputs compared on the falling edge.
// Source holds an offered word until the model says it was accepted.
module tb_fir_coeff_loader;

    localparam int W = 18;
    localparam int N = 4;

    logic             clock;
    logic             reset;
    logic             clk_ena;
    logic             load_valid;
    logic             load_ready;
    logic [W-1:0]     load_data;
    logic             load_last;
    logic [2*N*W-1:0] coeffs;
    logic             busy;
    logic             swap_done;
    logic             len_err;

    fir_coeff_loader #(.COEFF_W(W), .NUM_UNIQUE(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .clk_ena    (clk_ena),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .coeffs     (coeffs),
        .busy       (busy),
        .swap_done  (swap_done),
        .len_err    (len_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef logic [N-1:0][W-1:0] set_t;

    typedef struct {
        bit     rst;
        bit     ena;
        bit     vld;
        logic [W-1:0] dat;
        bit     lst;
        bit     rdy;
        bit     bsy;
        bit     swp;
        bit     err;
        set_t   set;
    } vec_t;

    vec_t tab[$];

    // Set-level reference: collected words, a staged complete set, and the active set.
    logic [W-1:0] m_words[$];
    set_t         m_active;
    set_t         m_staged;
    bit           m_commit;
    bit           m_swap;
    bit           m_err;

    function automatic logic [2*N*W-1:0] mirror(input set_t s);
        logic [2*N*W-1:0] r;
        r = '0;
        for (int k = 0; k < 2 * N; k++)
            r[k*W +: W] = (k < N) ? s[k] : s[2*N-1-k];
        return r;
    endfunction

    function automatic void add(input bit rst, input bit ena, input bit vld, input logic [W-1:0] dat,
                                input bit lst, input bit rdy, input bit bsy, input bit swp,
                                input bit err, input set_t set);
        vec_t v;
        v.rst = rst; v.ena = ena; v.vld = vld; v.dat = dat; v.lst = lst;
        v.rdy = rdy; v.bsy = bsy; v.swp = swp; v.err = err; v.set = set;
        tab.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [2*N*W-1:0] act, input logic [2*N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ena, input bit xfer, input logic [W-1:0] dat,
                              input bit lst);
        m_swap = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_words.delete();
            m_active = '0;
            m_staged = '0;
            m_commit = 1'b0;
        end else if (m_commit) begin
            if (ena) begin
                m_active = m_staged;
                m_swap   = 1'b1;
                m_commit = 1'b0;
            end
        end else if (xfer) begin
            m_words.push_back(dat);
            if (lst) begin
                if (m_words.size() == N) begin
                    for (int i = 0; i < N; i++) m_staged[i] = m_words[i];
                    m_commit = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_words.delete();
            end else if (m_words.size() == N) begin
                m_err = 1'b1;
                m_words.delete();
            end
        end
    endtask

    // One clock cycle: drive, compare on the falling edge, advance the model on the rising edge.
    task automatic cycle(input bit rst, input bit ena, input bit vld, input logic [W-1:0] dat,
                         input bit lst, input bit use_tab, input vec_t v, input int row);
        bit m_rdy;
        reset = rst; clk_ena = ena; load_valid = vld; load_data = dat; load_last = lst;
        @(negedge clock);
        m_rdy = !rst && !m_commit;
        chk("m_ready", {143'd0, load_ready}, {143'd0, m_rdy});
        chk("m_busy",  {143'd0, busy},       {143'd0, m_commit || (m_words.size() != 0)});
        chk("m_swap",  {143'd0, swap_done},  {143'd0, m_swap});
        chk("m_lerr",  {143'd0, len_err},    {143'd0, m_err});
        chk("m_coeffs", coeffs, mirror(m_active));
        if (use_tab) begin
            chk($sformatf("row%0d_ready", row),  {143'd0, load_ready}, {143'd0, v.rdy});
            chk($sformatf("row%0d_busy", row),   {143'd0, busy},       {143'd0, v.bsy});
            chk($sformatf("row%0d_swap", row),   {143'd0, swap_done},  {143'd0, v.swp});
            chk($sformatf("row%0d_lenerr", row), {143'd0, len_err},    {143'd0, v.err});
            chk($sformatf("row%0d_coeffs", row), coeffs, mirror(v.set));
        end
        @(posedge clock);
        model_edge(rst, ena, vld && m_rdy, dat, lst);
        #1;
    endtask

    task automatic run(input bit rst, input bit ena, input bit vld, input logic [W-1:0] dat,
                       input bit lst);
        vec_t dummy;
        dummy = '{default: '0};
        cycle(rst, ena, vld, dat, lst, 1'b0, dummy, 0);
    endtask

    initial begin
        set_t s0, sa, sb, sc;
        bit pend;
        logic [W-1:0] pd;
        bit pl;
        int pos;

        s0 = '0;
        sa = {18'h00400, 18'h00300, 18'h00200, 18'h00100};
        sb = {18'h00044, 18'h00033, 18'h00022, 18'h00011};
        sc = {18'h00004, 18'h00003, 18'h00002, 18'h00001};

        // rst ena vld dat lst | rdy bsy swp err active-set
        add(1,0,0,18'h0,0,      0,0,0,0, s0);
        add(1,0,0,18'h0,0,      0,0,0,0, s0);
        add(0,1,1,18'h00100,0,  1,0,0,0, s0);
        add(0,1,1,18'h00200,0,  1,1,0,0, s0);
        add(0,1,1,18'h00300,0,  1,1,0,0, s0);
        add(0,1,1,18'h00400,1,  1,1,0,0, s0);
        add(0,1,0,18'h0,0,      0,1,0,0, s0);
        add(0,1,0,18'h0,0,      1,0,1,0, sa);
        add(0,0,0,18'h0,0,      1,0,0,0, sa);
        add(0,0,1,18'h00011,0,  1,0,0,0, sa);
        add(0,0,1,18'h00022,0,  1,1,0,0, sa);
        add(0,0,1,18'h00033,0,  1,1,0,0, sa);
        add(0,0,1,18'h00044,1,  1,1,0,0, sa);
        for (int i = 0; i < 10; i++) add(0,0,0,18'h0,0, 0,1,0,0, sa);
        add(0,1,0,18'h0,0,      0,1,0,0, sa);
        add(0,0,0,18'h0,0,      1,0,1,0, sb);
        add(0,0,1,18'h00055,0,  1,0,0,0, sb);
        add(0,0,1,18'h00066,1,  1,1,0,0, sb);
        add(0,0,0,18'h0,0,      1,0,0,1, sb);
        add(0,0,0,18'h0,0,      1,0,0,0, sb);
        add(0,0,1,18'h000A1,0,  1,0,0,0, sb);
        add(0,0,1,18'h000A2,0,  1,1,0,0, sb);
        add(0,0,1,18'h000A3,0,  1,1,0,0, sb);
        add(0,0,1,18'h000A4,0,  1,1,0,0, sb);
        add(0,0,0,18'h0,0,      1,0,0,1, sb);
        add(0,1,1,18'h00001,0,  1,0,0,0, sb);
        add(0,1,1,18'h00002,0,  1,1,0,0, sb);
        add(0,1,1,18'h00003,0,  1,1,0,0, sb);
        add(0,1,1,18'h00004,1,  1,1,0,0, sb);
        add(0,1,0,18'h0,0,      0,1,0,0, sb);
        add(0,1,0,18'h0,0,      1,0,1,0, sc);
        add(0,0,0,18'h0,0,      1,0,0,0, sc);

        reset = 1'b1; clk_ena = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        m_active = '0; m_staged = '0; m_commit = 1'b0; m_swap = 1'b0; m_err = 1'b0;
        @(posedge clock);
        model_edge(1'b1, 1'b0, 1'b0, '0, 1'b0);
        #1;

        for (int i = 0; i < tab.size(); i++)
            cycle(tab[i].rst, tab[i].ena, tab[i].vld, tab[i].dat, tab[i].lst, 1'b1, tab[i], i);

        // Word held during a stalled commit becomes the first word of the next set.
        run(0,0,1,18'h00005,0); run(0,0,1,18'h00006,0);
        run(0,0,1,18'h00007,0); run(0,0,1,18'h00008,1);
        for (int i = 0; i < 5; i++) run(0,0,1,18'h3FFFF,0);
        run(0,1,1,18'h3FFFF,0);
        run(0,0,1,18'h3FFFF,0);
        run(0,1,1,18'h00002,0); run(0,1,1,18'h00003,0); run(0,1,1,18'h00004,1);
        run(0,1,0,18'h0,0); run(0,1,0,18'h0,0);
        chk("held_word_tap0", {126'd0, coeffs[W-1:0]}, {126'd0, 18'h3FFFF});
        chk("held_word_tap7", {126'd0, coeffs[7*W +: W]}, {126'd0, 18'h3FFFF});

        // Reset after two words, then reset while a set awaits its swap.
        run(0,0,1,18'h00077,0); run(0,0,1,18'h00078,0);
        run(1,0,0,18'h0,0);
        run(0,0,0,18'h0,0);
        chk("rst_load_coeffs", coeffs, '0);
        run(0,0,1,18'h00101,0); run(0,0,1,18'h00102,0);
        run(0,0,1,18'h00103,0); run(0,0,1,18'h00104,1);
        run(0,0,0,18'h0,0);
        run(1,1,0,18'h0,0);
        run(0,1,0,18'h0,0); run(0,1,0,18'h0,0);
        chk("rst_commit_coeffs", coeffs, '0);
        run(0,1,1,18'h00201,0); run(0,1,1,18'h00202,0);
        run(0,1,1,18'h00203,0); run(0,1,1,18'h00204,1);
        run(0,1,0,18'h0,0); run(0,0,0,18'h0,0);
        chk("after_rst_tap4", {126'd0, coeffs[4*W +: W]}, {126'd0, 18'h00204});

        // Random traffic with gaps, held words, occasional bad lengths and sparse clk_ena.
        pend = 1'b0; pd = '0; pl = 1'b0; pos = 0;
        for (int i = 0; i < 400; i++) begin
            bit ena, acc;
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend = 1'b1;
                pd   = W'($urandom);
                pl   = (pos == N - 1);
                if ($urandom_range(0, 11) == 0) pl = !pl;
            end
            ena = ($urandom_range(0, 3) == 0);
            acc = pend && !m_commit;
            run(1'b0, ena, pend, pd, pl);
            if (acc) begin
                pend = 1'b0;
                if (pl || pos == N - 1) pos = 0;
                else                    pos++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Run-time coefficient writer for the 8-tap symmetric FIR datapath. It accepts the unique half of a coefficient set as a ready/valid word stream and stages it in a shadow bank. It mirrors the set to all taps and swaps it into the active bank atomically on a sample boundary (`clk_ena`). Its packed output replaces the fixed coefficient ROMs feeding the multiply-add stages, so the filter response can change without disturbing a sample in flight.

## Interface
Parameters:
- `COEFF_W`, 18, coefficient width (two's complement).
- `NUM_UNIQUE`, 4, unique coefficients per set; tap count = 2*`NUM_UNIQUE`.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clk_ena`  in  1  FIR sample strobe; the active bank swaps only on a cycle where this is high.
- `load_valid`  in  1  word on `load_data` is valid.
- `load_ready`  out  1  loader accepts a word this cycle.
- `load_data`  in  `COEFF_W`  coefficient word, index order 0..`NUM_UNIQUE`-1.
- `load_last`  in  1  marks the final word of a set.
- `coeffs`  out  2*`NUM_UNIQUE`*`COEFF_W`  active tap k at bits [k*`COEFF_W` +: `COEFF_W`].
- `busy`  out  1  a set is being loaded or awaits swap.
- `swap_done`  out  1  one-cycle pulse, cycle after the active bank updated.
- `len_err`  out  1  one-cycle pulse, set length wrong; set discarded.

## Operation
- A transfer occurs on a rising edge with `load_valid` & `load_ready`.
- `load_ready` is decoded from state only: 1 in IDLE/LOAD, 0 in COMMIT and during reset.
- States:
  - IDLE:
    - Transfer with `load_last`=0: shadow[0] <= data, idx <= 1, go LOAD.
    - Transfer with `load_last`=1: pulse `len_err`, stay IDLE (unless `NUM_UNIQUE`=1, then go COMMIT).
  - LOAD: each transfer writes shadow[idx] and increments idx.
    - `load_last`=1 at idx=`NUM_UNIQUE`-1: go COMMIT.
    - `load_last`=1 at idx<`NUM_UNIQUE`-1: pulse `len_err`, go IDLE.
    - `load_last`=0 at idx=`NUM_UNIQUE`-1: pulse `len_err`, go IDLE. Following words start a new set.
  - COMMIT: wait for `clk_ena`=1. On that edge active[i] <= shadow[i] for all i, go IDLE.
- Mirroring: tap k = active[k] for k<`NUM_UNIQUE`, and active[2*`NUM_UNIQUE`-1-k] otherwise. Taps 0/7, 1/6, 2/5 and 3/4 are identical.
- Shadow writes never alter `coeffs`. `coeffs` changes only on the COMMIT swap edge.
- A discarded set leaves the active bank untouched. Stale shadow contents are irrelevant, since a complete set overwrites all entries.
- `busy` = (state != IDLE).

## Timing
- Reset: state IDLE, idx 0, shadow and active banks all zero.
  - `coeffs`=0, `swap_done`=0, `len_err`=0, `busy`=0.
  - `load_ready`=0 while `reset` is high; it is 1 the first cycle after.
- Reset mid-load or in COMMIT: set discarded, no `swap_done`, active bank returns to zero.
- Last word accepted at edge N: COMMIT from N, `load_ready`=0 from that cycle.
  - Earliest swap is edge N+1, if `clk_ena`=1 in cycle N..N+1.
  - `coeffs` shows the new set after the swap edge S. `swap_done`=1 for the cycle after S only.
  - Back in IDLE after S, `load_ready`=1. Back-to-back sets therefore need at least `NUM_UNIQUE`+1 cycles each.
- `clk_ena` held low leaves COMMIT stalled indefinitely, with `load_ready`=0.
- `clk_ena` outside COMMIT has no effect.
- `len_err` asserts the cycle after the offending transfer edge, for one cycle. `load_ready` stays 1 across the error.
- `load_valid` with `load_ready`=0 is not a transfer. The source must hold the word until accepted.

## Test plan
- **Reset:** reset 3 cycles → `coeffs`=0, `busy`=0, `load_ready`=0 during reset and 1 after.
- **Basic load:** load 0x00100, 0x00200, 0x00300, 0x00400 (last on 4th) with `clk_ena` held 1.
  - Swap on the edge after the last word, then `swap_done` for 1 cycle.
  - Taps 0..7 = 0x00100, 0x00200, 0x00300, 0x00400, 0x00400, 0x00300, 0x00200, 0x00100.
- **Stalled commit:** `clk_ena`=0 for 10 cycles after the last word.
  - `coeffs` unchanged and `load_ready`=0 throughout.
  - Raise `clk_ena` for 1 cycle → swap on that edge.
- **Length errors:**
  - `load_last` on the 2nd word → `len_err` pulse, `coeffs` unchanged.
  - 4 words with no `load_last` → `len_err` after the 4th.
  - A following valid 4-word set loads correctly.
- **Random valid gaps:** random `load_valid` gaps, plus `load_valid` held during COMMIT (0x3FFFF offered).
  - No word accepted while in COMMIT.
  - The next set begins with the held word after `swap_done`.
- **Reset mid-operation:** reset after 2 words, and again during COMMIT.
  - No `swap_done`, `coeffs`=0.
  - The next full set loads normally.
